// File: rtl/legal_move_filter.sv
// -----------------------------------------------------------------------------
// legal_move_filter
//
// Turns a piece's pseudo-legal destination mask into a legal mask. Each
// candidate destination is applied on the board through the sim handshake.
// The check evaluator's verdict for the mover's colour is sampled on sim_ack.
// The board is then reverted through the restore handshake. A candidate that
// leaves the mover's own king attacked is removed from the mask.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             1-cycle pulse, begins a run when not busy
//   abort             level, cancels the current run (board is still restored)
//   any_mode          stop at the first legal move found (latched at start)
//   side              colour to move, 0 white / 1 black (latched at start)
//   src_sq            source square of the piece (latched at start)
//   cand_mask         pseudo-legal destination mask (latched at start)
//   sim_req/ack       apply move sim_src->sim_dst; check[] is valid with ack
//   check             check[c]=1: king of colour c attacked
//   restore_req/ack   revert board to the pre-simulation position
//   busy              run in progress
//   done              1-cycle pulse, legal_mask/legal_count/any_legal valid
//   legal_mask        filtered mask, held until the next start
//   legal_count       number of moves found legal
//   any_legal         legal_count != 0
//   error             sticky handshake-timeout flag, cleared by next start
// -----------------------------------------------------------------------------
module legal_move_filter #(
  parameter int SQ_BITS  = 6,
  parameter int TIMEOUT  = 255,
  parameter int CNT_BITS = SQ_BITS + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    any_mode,
  input  logic                    side,
  input  logic [SQ_BITS-1:0]      src_sq,
  input  logic [2**SQ_BITS-1:0]   cand_mask,
  output logic                    sim_req,
  output logic [SQ_BITS-1:0]      sim_src,
  output logic [SQ_BITS-1:0]      sim_dst,
  input  logic                    sim_ack,
  input  logic [1:0]              check,
  output logic                    restore_req,
  input  logic                    restore_ack,
  output logic                    busy,
  output logic                    done,
  output logic [2**SQ_BITS-1:0]   legal_mask,
  output logic [CNT_BITS-1:0]     legal_count,
  output logic                    any_legal,
  output logic                    error
);

  localparam int NSQ        = 2**SQ_BITS;
  // Wide enough to hold TIMEOUT itself; at least one bit when TIMEOUT is 0.
  localparam int WAIT_BITS  = $clog2(TIMEOUT + 2);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_SIM,
    S_RESTORE,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [NSQ-1:0]       work_q, work_d;      // candidates not yet tested
  logic [NSQ-1:0]       mask_q, mask_d;
  logic [CNT_BITS-1:0]  count_q, count_d;
  logic [SQ_BITS-1:0]   dst_q, dst_d;
  logic [SQ_BITS-1:0]   src_q, src_d;
  logic                 side_q, side_d;
  logic                 any_q, any_d;
  logic                 abort_q, abort_d;    // abort seen; finish restore then idle
  logic [WAIT_BITS-1:0] wait_q, wait_d;      // cycles spent waiting on an ack
  logic                 error_q, error_d;

  logic [NSQ-1:0]       low_onehot;
  logic [SQ_BITS-1:0]   low_idx;
  logic                 wait_expired;

  // Lowest pending candidate in one cycle: isolate the lowest set bit with
  // two's complement, then OR together the indices of the (single) set bit.
  always_comb begin
    low_onehot = work_q & (~work_q + NSQ'(1));
    low_idx    = '0;
    for (int i = 0; i < NSQ; i++) begin
      if (low_onehot[i]) low_idx = low_idx | SQ_BITS'(i);
    end
  end

  assign wait_expired = TIMEOUT_EN && (wait_q == WAIT_BITS'(TIMEOUT));

  // NOTE: every variable assigned below gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    mask_d  = mask_q;
    count_d = count_q;
    dst_d   = dst_q;
    src_d   = src_q;
    side_d  = side_q;
    any_d   = any_q;
    abort_d = abort_q;
    wait_d  = wait_q;
    error_d = error_q;

    unique case (state_q)
      // busy is low in DONE as well, so a start there is honoured too.
      // A simultaneous abort suppresses the run.
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start && !abort) begin
          work_d  = cand_mask;
          mask_d  = cand_mask;
          count_d = '0;
          src_d   = src_sq;
          side_d  = side;
          any_d   = any_mode;
          abort_d = 1'b0;
          error_d = 1'b0;
          wait_d  = '0;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (work_q == '0) begin
          state_d = S_DONE;
        end else begin
          dst_d   = low_idx;
          work_d  = work_q & ~low_onehot;
          wait_d  = '0;
          state_d = S_SIM;
        end
      end

      S_SIM: begin
        if (abort) begin
          // The board may already hold the move, so always revert it.
          abort_d = 1'b1;
          wait_d  = '0;
          state_d = S_RESTORE;
        end else if (sim_ack) begin
          if (check[side_q]) begin
            mask_d[dst_q] = 1'b0;
          end else if (count_q != CNT_BITS'(NSQ)) begin
            count_d = count_q + CNT_BITS'(1);
          end
          wait_d  = '0;
          state_d = S_RESTORE;
        end else if (wait_expired) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else if (TIMEOUT_EN) begin
          wait_d = wait_q + WAIT_BITS'(1);
        end
      end

      S_RESTORE: begin
        if (abort) abort_d = 1'b1;
        if (restore_ack) begin
          wait_d = '0;
          if (abort_q || abort) begin
            abort_d = 1'b0;
            state_d = S_IDLE;
          end else if (any_q && (count_q != '0)) begin
            // Early exit: untested candidates stay set in the mask.
            state_d = S_DONE;
          end else begin
            state_d = S_SCAN;
          end
        end else if (wait_expired) begin
          error_d = 1'b1;
          abort_d = 1'b0;
          state_d = S_DONE;
        end else if (TIMEOUT_EN) begin
          wait_d = wait_q + WAIT_BITS'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      mask_q  <= '0;
      count_q <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      side_q  <= 1'b0;
      any_q   <= 1'b0;
      abort_q <= 1'b0;
      wait_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      side_q  <= side_d;
      any_q   <= any_d;
      abort_q <= abort_d;
      wait_q  <= wait_d;
      error_q <= error_d;
    end
  end

  // Requests decode straight from state, so they fall the cycle after the ack
  // and sim_src/sim_dst are register outputs that cannot move mid-request.
  assign sim_req     = (state_q == S_SIM);
  assign restore_req = (state_q == S_RESTORE);
  assign sim_src     = src_q;
  assign sim_dst     = dst_q;
  assign busy        = (state_q == S_SCAN) || (state_q == S_SIM) ||
                       (state_q == S_RESTORE);
  assign done        = (state_q == S_DONE);
  assign legal_mask  = mask_q;
  assign legal_count = count_q;
  assign any_legal   = (count_q != '0);
  assign error       = error_q;

endmodule

// File: tb/tb_legal_move_filter.sv
// -----------------------------------------------------------------------------
// tb_legal_move_filter
//
// Drives legal_move_filter against a board/check-evaluator responder with
// random ack latencies, and compares each run with a reference model. The
// model tests candidates in ascending square order. A candidate whose
// destination is marked in-check is dropped. In any-mode, testing stops once
// one legal move has been found.
// -----------------------------------------------------------------------------
module tb_legal_move_filter;

  localparam int SQ_BITS = 6;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset, start, abort, any_mode, side;
  logic [5:0]  src_sq;
  logic [63:0] cand_mask;
  logic        sim_req, sim_ack, restore_req, restore_ack;
  logic [5:0]  sim_src, sim_dst;
  logic [1:0]  chk;
  logic        busy, done, any_legal, error;
  logic [63:0] legal_mask;
  logic [6:0]  legal_count;

  legal_move_filter #(.SQ_BITS(SQ_BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .any_mode(any_mode), .side(side), .src_sq(src_sq), .cand_mask(cand_mask),
    .sim_req(sim_req), .sim_src(sim_src), .sim_dst(sim_dst), .sim_ack(sim_ack),
    .check(chk), .restore_req(restore_req), .restore_ack(restore_ack),
    .busy(busy), .done(done), .legal_mask(legal_mask),
    .legal_count(legal_count), .any_legal(any_legal), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- board / check-evaluator responder ----------------
  logic [63:0] in_check_set = '0;  // destinations that leave the mover in check
  int          max_delay    = 0;
  bit          withhold     = 1'b0;
  bit          applied      = 1'b0;
  int          sim_log[$];

  initial begin
    int wcnt, dly, rcnt, rdly;
    wcnt = 0; dly = 0; rcnt = 0; rdly = 0;
    sim_ack = 1'b0; restore_ack = 1'b0; chk = 2'b00;
    forever begin
      @(posedge clk); #2;
      sim_ack     = 1'b0;
      restore_ack = 1'b0;
      chk         = 2'($urandom);   // garbage unless acked
      if (reset) begin
        wcnt = 0; rcnt = 0; applied = 1'b0;
      end else begin
        if (sim_req && !withhold) begin
          if (wcnt == 0) dly = $urandom_range(max_delay, 0);
          if (wcnt >= dly) begin
            sim_ack   = 1'b1;
            chk[side] = in_check_set[sim_dst];
            applied   = 1'b1;
            sim_log.push_back(int'(sim_dst));
            wcnt = 0;
          end else wcnt++;
        end else wcnt = 0;
        if (restore_req) begin
          if (rcnt == 0) rdly = $urandom_range(max_delay, 0);
          if (rcnt >= rdly) begin
            restore_ack = 1'b1;
            applied     = 1'b0;
            rcnt = 0;
          end else rcnt++;
        end else rcnt = 0;
      end
    end
  end

  // ---------------- per-cycle compare / capture ----------------
  logic [5:0]  run_src = '0;
  logic        prev_sim_req = 1'b0, prev_restore = 1'b0;
  logic [5:0]  prev_dst = '0;
  int          done_cnt = 0, restore_rises = 0, sim_rises = 0;
  int          done_cyc = 0, sim_rise_cyc = 0;
  logic [63:0] got_mask;
  logic [6:0]  got_count;
  logic        got_any, got_err, got_simreq;

  always @(negedge clk) begin
    if (!reset) begin
      check("req_exclusive", 64'(sim_req & restore_req), 64'd0);
      if (sim_req) check("sim_src", 64'(sim_src), 64'(run_src));
      if (sim_req && prev_sim_req) check("dst_stable", 64'(sim_dst), 64'(prev_dst));
      if (sim_req && !prev_sim_req) begin sim_rises++; sim_rise_cyc = cyc; end
      if (restore_req && !prev_restore) restore_rises++;
      if (done) begin
        done_cnt++;
        done_cyc   = cyc;
        got_mask   = legal_mask;
        got_count  = legal_count;
        got_any    = any_legal;
        got_err    = error;
        got_simreq = sim_req;
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
    prev_sim_req = sim_req;
    prev_restore = restore_req;
    prev_dst     = sim_dst;
  end

  // ---------------- reference model ----------------
  logic [63:0] exp_mask;
  int          exp_cnt;
  int          exp_order[$];

  task automatic model_run(input logic [63:0] cand, input logic [63:0] inchk,
                           input bit anym);
    exp_mask = cand;
    exp_cnt  = 0;
    exp_order.delete();
    for (int i = 0; i < 64; i++) begin
      if (cand[i]) begin
        if (anym && exp_cnt != 0) break;
        exp_order.push_back(i);
        if (inchk[i]) exp_mask[i] = 1'b0;
        else exp_cnt++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int start_cyc, d0, rr0;

  // One run from start to idle. abort_nth>0 raises abort as the nth sim_req
  // rises; bad_start pulses a conflicting start while busy.
  task automatic run_case(input logic [63:0] cand, input logic [63:0] inchk,
                          input bit anym, input bit sd, input logic [5:0] src,
                          input int abort_nth, input bit bad_start);
    int t, nrise;
    logic prev;
    model_run(cand, inchk, anym);
    in_check_set = inchk;
    side = sd; any_mode = anym; src_sq = src; cand_mask = cand; run_src = src;
    sim_log.delete();
    d0 = done_cnt; rr0 = restore_rises;
    start = 1'b1; start_cyc = cyc;
    tick();
    start = 1'b0;
    cand_mask = {$urandom, $urandom};   // latched copy must be used
    src_sq    = 6'($urandom);
    any_mode  = 1'($urandom);
    t = 0; nrise = 0; prev = 1'b0;
    while ((busy || done) && t < 2000) begin
      if (sim_req && !prev) begin
        nrise++;
        if (nrise == abort_nth) abort = 1'b1;
      end
      prev = sim_req;
      if (bad_start && t == 3 && busy) start = 1'b1;
      tick();
      abort = 1'b0; start = 1'b0;
      t++;
    end
    check("run_bound", 64'(t < 2000), 64'd1);
    if (abort_nth == 0 && !withhold) begin
      check("done_pulses", 64'(done_cnt - d0), 64'd1);
      check("mask", got_mask, exp_mask);
      check("count", 64'(got_count), 64'(exp_cnt));
      check("any_legal", 64'(got_any), 64'(exp_cnt != 0));
      check("error_clear", 64'(got_err), 64'd0);
      check("n_sims", 64'(sim_log.size()), 64'(exp_order.size()));
      for (int i = 0; i < exp_order.size() && i < sim_log.size(); i++)
        check($sformatf("order%0d", i), 64'(sim_log[i]), 64'(exp_order[i]));
      check("board_restored", 64'(applied), 64'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; any_mode = 1'b0; side = 1'b0;
    src_sq = '0; cand_mask = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sim_req", 64'(sim_req), 64'd0);
    check("rst_restore_req", 64'(restore_req), 64'd0);
    check("rst_mask", legal_mask, 64'd0);
    check("rst_count", 64'(legal_count), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_sim_dst", 64'(sim_dst), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // Empty mask: no simulation, done two cycles after start.
    max_delay = 2;
    run_case(64'd0, 64'd0, 1'b0, 1'b0, 6'd12, 0, 1'b0);
    check("empty_latency", 64'(done_cyc - start_cyc), 64'd2);
    check("empty_mask_lit", got_mask, 64'd0);
    check("empty_any_lit", 64'(got_any), 64'd0);

    // {3,10,63}, white, dst 10 leaves white in check.
    run_case((64'd1 << 3) | (64'd1 << 10) | (64'd1 << 63), 64'd1 << 10,
             1'b0, 1'b0, 6'd20, 0, 1'b0);
    check("ex1_mask_lit", got_mask, (64'd1 << 3) | (64'd1 << 63));
    check("ex1_count_lit", 64'(got_count), 64'd2);
    check("ex1_sim2_lit", 64'(sim_log.size() > 1 ? sim_log[1] : -1), 64'd10);

    // Any-mode {5,6,7}: 5 in check, 6 legal, 7 untested.
    run_case(64'hE0, 64'h20, 1'b1, 1'b1, 6'd40, 0, 1'b0);
    check("any_mask_lit", got_mask, 64'hC0);
    check("any_count_lit", 64'(got_count), 64'd1);
    check("any_nsims_lit", 64'(sim_log.size()), 64'd2);

    // Abort while simulating the second candidate.
    max_delay = 3;
    run_case((64'd1 << 1) | (64'd1 << 4) | (64'd1 << 9), 64'd0,
             1'b0, 1'b0, 6'd7, 2, 1'b0);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_restores", 64'(restore_rises - rr0), 64'd2);
    check("abort_board_restored", 64'(applied), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);

    // Start and abort together in idle: nothing starts.
    d0 = done_cnt;
    cand_mask = 64'hFF; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_idle", 64'(busy), 64'd0);
    repeat (3) tick();
    check("start_abort_no_done", 64'(done_cnt - d0), 64'd0);

    // Withheld sim_ack: timeout raises error and still pulses done.
    withhold = 1'b1;
    run_case(64'd1 << 2, 64'd0, 1'b0, 1'b0, 6'd3, 0, 1'b0);
    withhold = 1'b0;
    check("timeout_done", 64'(done_cnt - d0), 64'd1);
    check("timeout_error", 64'(got_err), 64'd1);
    check("timeout_req_low", 64'(got_simreq), 64'd0);
    check("timeout_within10", 64'(done_cyc - sim_rise_cyc <= 10), 64'd1);

    // Full board, never in check, zero-latency acks: count reaches 64.
    max_delay = 0;
    run_case('1, 64'd0, 1'b0, 1'b1, 6'd0, 0, 1'b0);
    check("full_count_lit", 64'(got_count), 64'd64);
    check("full_any_lit", 64'(got_any), 64'd1);

    // Randomized runs.
    for (int r = 0; r < 30; r++) begin
      logic [63:0] c, k;
      max_delay = $urandom_range(4, 0);
      c = {$urandom, $urandom} & {$urandom, $urandom};
      if (r % 7 == 3) c = c & {$urandom, $urandom} & {$urandom, $urandom};
      k = {$urandom, $urandom};
      run_case(c, k, 1'($urandom), 1'($urandom), 6'($urandom), 0, r == 5);
    end

    // Reset mid-run: everything clears on the next cycle.
    max_delay = 1;
    in_check_set = '0; side = 1'b0; any_mode = 1'b0; cand_mask = '1;
    src_sq = 6'd9; run_src = 6'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_sim_req", 64'(sim_req), 64'd0);
    check("mrst_restore_req", 64'(restore_req), 64'd0);
    check("mrst_mask", legal_mask, 64'd0);
    check("mrst_count", 64'(legal_count), 64'd0);
    check("mrst_any", 64'(any_legal), 64'd0);
    check("mrst_error", 64'(error), 64'd0);
    check("mrst_sim_src", 64'(sim_src), 64'd0);
    check("mrst_sim_dst", 64'(sim_dst), 64'd0);
    tick();
    reset = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
